// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, majority-voted mid-bit samples, valid/ready output.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx #(
    parameter int CLOCK_IN          = 100_000_000,
    parameter int BAUD_RATE         = 230_400,
    parameter int OVERSAMPLING_RATE = 8,
    parameter int DATA_BITS         = 8,
    parameter int PARITY_ODD        = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rx_in,
    input  logic                 ready_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err_out,
    output logic                 parity_err_out,
    output logic                 overrun_err_out,
    output logic                 busy_out
);

    localparam int TICK_DIV = CLOCK_IN / (OVERSAMPLING_RATE * BAUD_RATE);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(OVERSAMPLING_RATE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLING_RATE - 1);
    localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLING_RATE / 2 - 1);
    localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLING_RATE / 2);
    localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLING_RATE / 2 + 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    generate
        if (OVERSAMPLING_RATE < 4 || TICK_DIV < 2 || DATA_BITS < 2 ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
            $error("uart_rx: unsupported parameter combination");
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state, state_next;
    logic [TW-1:0]          div;
    logic                   tick;
    logic [1:0]             sync;
    logic                   line;
    logic [SW-1:0]          s;
    logic [IW-1:0]          idx;
    logic [2:0]             smp;
    logic [DATA_BITS-1:0]   shreg;
    logic                   vote, stop_vote, at_last, done, good, load;

    assign tick     = (div == TICK_LAST);
    assign line     = sync[1];
    assign at_last  = tick && (s == S_LAST);
    assign vote     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    // Stop bit completes on its third sample, so that sample comes straight off the line.
    assign stop_vote = (smp[0] & smp[1]) | (smp[0] & line) | (smp[1] & line);
    assign load     = done && good && (!valid_out || ready_in);
    assign busy_out = (state != IDLE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        unique case (state)
            IDLE:   if (tick && !line) state_next = START;
            START:  if (at_last) state_next = vote ? IDLE : DATA;
            DATA: begin
                if (at_last && idx == I_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (at_last) state_next = STOP;
`endif
            STOP: begin
                if (tick && s == S_V2) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div             <= '0;
            sync            <= 2'b11;
            s               <= '0;
            idx             <= '0;
            smp             <= '0;
            shreg           <= '0;
            data_out        <= '0;
            valid_out       <= 1'b0;
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
        end else begin
            div  <= tick ? '0 : div + 1'b1;
            sync <= {sync[0], rx_in};
            if (tick) begin
                if (state == IDLE || at_last || done) s <= '0;
                else                                  s <= s + 1'b1;
                if (s == S_V0) smp[0] <= line;
                if (s == S_V1) smp[1] <= line;
                if (s == S_V2) smp[2] <= line;
            end
            if (state == DATA && at_last) begin
                shreg <= {vote, shreg[DATA_BITS-1:1]};
                idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
            end
            frame_err_out   <= done && !stop_vote;
            overrun_err_out <= done && good && valid_out && !ready_in;
            if (load) begin
                data_out  <= shreg;
                valid_out <= 1'b1;
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perr           <= 1'b0;
            parity_err_out <= 1'b0;
        end else begin
            parity_err_out <= done && perr;
            if (state == PARITY && at_last)
                perr <= vote ^ (^shreg) ^ 1'(PARITY_ODD);
        end
    end

    assign good = stop_vote && !perr;
`else
    assign parity_err_out = 1'b0;
    assign good           = stop_vote;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at default parameters: table of whole frames plus hand-written
// sequences for false start, handshake, reset mid-frame and line break.
module tb_uart_rx;

    localparam int BIT = 432;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       rx_in = 1'b1;
    logic       ready_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, frame_err_out, parity_err_out, overrun_err_out, busy_out;

    int n_chk = 0;
    int n_fail = 0;
    int vcnt = 0;

    uart_rx dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rx_in           (rx_in),
        .ready_in        (ready_in),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .frame_err_out   (frame_err_out),
        .parity_err_out  (parity_err_out),
        .overrun_err_out (overrun_err_out),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] data;
        logic       valid, ferr, perr, ovr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par, stop, ready;
        logic [7:0] exp_data;
        logic       exp_valid, exp_ferr, exp_perr, exp_ovr;
        int         exp_vcyc;
    } vec_t;

    exp_t sbq[$];
    exp_t e;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // An output event is any error pulse or a freshly loaded byte.
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
        end else begin
            if (valid_out) vcnt <= vcnt + 1;
            if (frame_err_out || parity_err_out || overrun_err_out ||
                (valid_out && (!prev_valid || prev_ready))) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: data=0x%0h valid=%0b ferr=%0b perr=%0b ovr=%0b, expected no event",
                             data_out, valid_out, frame_err_out, parity_err_out, overrun_err_out);
                end else begin
                    e = sbq.pop_front();
                    check("sb_data",  int'(data_out),        int'(e.data));
                    check("sb_valid", int'(valid_out),       int'(e.valid));
                    check("sb_ferr",  int'(frame_err_out),   int'(e.ferr));
                    check("sb_perr",  int'(parity_err_out),  int'(e.perr));
                    check("sb_ovr",   int'(overrun_err_out), int'(e.ovr));
                end
            end
            prev_valid <= valid_out;
            prev_ready <= ready_in;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        rx_in = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_cyc(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = par;
        wait_cyc(BIT);
`endif
        rx_in = stop;
        wait_cyc(BIT);
        rx_in = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (sbq.size() != 0 && k < 3 * BIT) begin
            wait_cyc(1);
            k++;
        end
        check(name, sbq.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        ready_in = v.ready;
        wait_cyc(3);
        vcnt = 0;
        sbq.push_back('{v.exp_data, v.exp_valid, v.exp_ferr, v.exp_perr, v.exp_ovr});
        send_frame(v.data, v.par, v.stop);
        wait_cyc(2 * BIT);
        wait_drain($sformatf("vec%0d_drain", n));
        check($sformatf("vec%0d_busy_idle", n), int'(busy_out), 0);
        if (v.exp_vcyc >= 0) check($sformatf("vec%0d_valid_cycles", n), vcnt, v.exp_vcyc);
    endtask

`ifdef UART_RX_PARITY_EN
    localparam int NV = 8;
    localparam int BREAK_LEN = 9360;
`else
    localparam int NV = 6;
    localparam int BREAK_LEN = 8500;
`endif

    vec_t vecs[NV];

    initial begin
        //           data   par   stop  rdy   exp_d  v     ferr  perr  ovr   vcyc
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, -1};
        vecs[3] = '{8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, -1};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, -1};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
`ifdef UART_RX_PARITY_EN
        vecs[6] = '{8'h07, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1};
`endif

        wait_cyc(5);
        check("rst_valid", int'(valid_out), 0);
        check("rst_data",  int'(data_out), 0);
        check("rst_ferr",  int'(frame_err_out), 0);
        check("rst_perr",  int'(parity_err_out), 0);
        check("rst_ovr",   int'(overrun_err_out), 0);
        check("rst_busy",  int'(busy_out), 0);
        rst_in = 1'b0;
        wait_cyc(10);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // One-cycle ready: valid drops on the following edge, data held until then.
        ready_in = 1'b1;
        @(negedge clk_in);
        check("hs_valid_before", int'(valid_out), 1);
        check("hs_data_before",  int'(data_out), 'h11);
        @(posedge clk_in);
        #1 ready_in = 1'b0;
        @(negedge clk_in);
        check("hs_valid_after", int'(valid_out), 0);
        wait_cyc(2);

        for (int i = 4; i < NV; i++) run_vec(vecs[i], i);

        // False start: 100-clock glitch.
        ready_in = 1'b0;
        rx_in = 1'b0;
        wait_cyc(100);
        rx_in = 1'b1;
        wait_cyc(50);
        check("fs_busy_mid", int'(busy_out), 1);
        wait_cyc(BIT - 50);
        check("fs_busy_idle", int'(busy_out), 0);
        check("fs_no_valid", int'(valid_out), 0);

        // Reset during data bit 3 with a byte pending.
        sbq.push_back('{8'h33, 1'b1, 1'b0, 1'b0, 1'b0});
        send_frame(8'h33, 1'b0, 1'b1);
        wait_cyc(BIT);
        wait_drain("pre_rst_drain");
        rx_in = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 3; i++) begin
            rx_in = 1'(8'h96 >> i);
            wait_cyc(BIT);
        end
        rx_in = 1'b0;
        wait_cyc(200);
        check("mid_busy", int'(busy_out), 1);
        rst_in = 1'b1;
        rx_in = 1'b1;
        #1;
        check("mrst_valid", int'(valid_out), 0);
        check("mrst_data",  int'(data_out), 0);
        check("mrst_busy",  int'(busy_out), 0);
        check("mrst_ferr",  int'(frame_err_out), 0);
        check("mrst_ovr",   int'(overrun_err_out), 0);
        wait_cyc(3);
        rst_in = 1'b0;
        wait_cyc(2 * BIT);
        check("post_rst_busy", int'(busy_out), 0);
        sbq.push_back('{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0});
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_cyc(BIT);
        wait_drain("post_rst_drain");

        // Break: two framing errors, pending byte untouched, then recovery.
        sbq.push_back('{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0});
        sbq.push_back('{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0});
        rx_in = 1'b0;
        wait_cyc(BREAK_LEN);
        rx_in = 1'b1;
        wait_cyc(2 * BIT);
        wait_drain("break_drain");
        check("break_busy_idle", int'(busy_out), 0);
        check("break_data_kept", int'(data_out), 'h5A);
        ready_in = 1'b1;
        wait_cyc(2);
        check("final_valid_clear", int'(valid_out), 0);
        ready_in = 1'b0;

        check("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the cycle budget");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the receive counterpart of the UART baud generator. Derives an internal oversample tick from the system clock, synchronises the asynchronous serial line, validates start bits, majority-votes each bit at mid-bit, and presents completed bytes on a valid/ready handshake with framing and overrun error flags. Sits between the `rx` pad and the byte-stream consumer.

## Interface
- `CLOCK_IN`, 100_000_000: input clock frequency, Hz.
- `BAUD_RATE`, 230_400: line rate, bit/s.
- `OVERSAMPLING_RATE`, 8: ticks per bit; must be ≥4.
- `DATA_BITS`, 8: payload bits per frame, LSB first.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd; used only when parity is compiled in.
- Local: `TICK_DIV = CLOCK_IN / (OVERSAMPLING_RATE * BAUD_RATE)` (integer truncation; 54 at defaults); must be ≥2.

Ports:
- `clk_in`  in  1  system clock, all logic on rising edge.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rx_in`  in  1  asynchronous serial line, idle high.
- `ready_in`  in  1  consumer accepts `data_out` this cycle.
- `data_out`  out  DATA_BITS  last accepted frame payload.
- `valid_out`  out  1  `data_out` holds an unconsumed byte.
- `frame_err_out`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err_out`  out  1  one-cycle pulse: parity mismatch.
- `overrun_err_out`  out  1  one-cycle pulse: frame completed while `valid_out` high.
- `busy_out`  out  1  high whenever the state is not IDLE.

## Operation
- Tick generator: free-running counter 0..TICK_DIV-1, one-cycle `tick` at TICK_DIV-1, wraps to 0.
- Line synchroniser: 2 flip-flops, reset to 1; all logic uses the second stage.
- Sample counter `s` runs 0..OS-1 per bit, advancing on `tick`. Votes use samples at `s` = OS/2-1, OS/2, OS/2+1; a bit value is the majority of 3.
- States:
  - IDLE: on `tick` with synced line 0 → START, `s` = 0.
  - START: at `s` = OS-1, vote 0 → DATA, bit index 0; vote 1 → IDLE (false start, no output, no error).
  - DATA: at `s` = OS-1, shift the vote into the shift register LSB-first; after bit DATA_BITS-1 → PARITY (if compiled in) else STOP.
  - PARITY: at `s` = OS-1, compare the vote against the computed parity → STOP.
  - STOP: at `s` = OS/2+1 (immediately after the third vote) → IDLE and complete the frame. Half a bit of resync margin.
- Frame completion:
  - Stop vote 0: `frame_err_out` pulses.
  - Parity mismatch: `parity_err_out` pulses.
  - Either error: `data_out`/`valid_out` unchanged, and both flags may pulse together.
  - No error and `valid_out` low: load `data_out`, set `valid_out`.
  - No error and `valid_out` high, same cycle as `ready_in`: the old byte is consumed, the new one is loaded, and `valid_out` stays high.
  - No error and `valid_out` high, no `ready_in`: `overrun_err_out` pulses, the new byte is dropped, and `data_out` is kept.
- Handshake: `valid_out` stays high until a cycle with `ready_in` = 1, then clears on the next edge. `data_out` is stable while `valid_out` is high.
- Line held low (break): frames a framing error per frame time; no lockup.

## Timing
- Reset (async assert): all outputs 0, state IDLE, counters 0, synchroniser 1. Takes effect mid-frame immediately; the partial frame is discarded with no flags.
- Start detection latency: ≤ 2 + TICK_DIV cycles after the `rx_in` fall.
- `valid_out` and error pulses are registered: they assert on the edge after the STOP-state `tick` at `s` = OS/2+1.
- Frame time, start bit to completion: (1 + DATA_BITS [+1 parity]) × OS + OS/2+2 ticks.
- Widths: `s` is $clog2(OS) bits, the bit index is $clog2(DATA_BITS) bits, the tick counter is $clog2(TICK_DIV) bits; no counter overflows past its terminal value.

## Configuration
- `UART_RX_PARITY_EN` defined: a PARITY state follows DATA. Parity is the XOR of the data bits, inverted when PARITY_ODD = 1, and a mismatch drives `parity_err_out`.
- Not defined: no PARITY state or parity logic; `parity_err_out` is tied to 0.

## Test plan
Defaults apply: TICK_DIV 54, 432 clocks per bit.
- 0xA5 frame, `ready_in` = 1 → `valid_out` one cycle with `data_out` = 0xA5, no error pulses, `busy_out` low afterwards.
- `rx_in` low for 100 clocks then high → no `valid_out`, no errors, return to IDLE within one bit time.
- 0x3C frame with the stop bit held low → one `frame_err_out` pulse, `valid_out` stays 0, `data_out` unchanged.
- 0x11 then 0x22 back-to-back with `ready_in` = 0 → `valid_out` high with 0x11, `overrun_err_out` pulse at the end of 0x22, `data_out` stays 0x11. Then `ready_in` = 1 for one cycle → `valid_out` low on the next edge.
- `rst_in` pulsed during data bit 3 → all outputs 0 at once. After release, a 0x5A frame is received correctly.
- `UART_RX_PARITY_EN`, PARITY_ODD = 0, 0x07 sent with parity bit 0 → `parity_err_out` pulse, no `valid_out`. Same data with parity bit 1 → `valid_out` with 0x07.
